// File: rtl/present_core_rst_seq_if.sv
// Signal bundle between the reset sequencer and its environment
// (PLL wrapper on one side, downstream reset consumers on the other).
// All signals are level-based status/control lines.
// There is no valid/ready handshake on this interface.
// Values are sampled by the consumer whenever it needs them.
interface present_core_rst_seq_if;
  logic       locked;        // PLL lock indication, asynchronous to clk
  logic       pll_rst;       // reset to the PLL, active high
  logic       sys_rst;       // reset to downstream logic, active high
  logic       ready;         // high only while the sequencer is in RUN
  logic [7:0] relock_count;  // saturating count of recovery events
  logic [1:0] state;         // current sequencer state (debug/status)

  // Sequencer side
  modport master (
    input  locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output relock_count,
    output state
  );

  // Environment side (PLL wrapper / reset consumers / bench)
  modport slave (
    output locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  relock_count,
    input  state
  );
endinterface

// File: rtl/present_core_rst_seq.sv
// Reset and clock-health sequencer for the PRESENT core.
// It pulses the PLL reset and waits for lock.
// Once lock has been stable for a settling window, the core reset is released.
// The PLL is re-sequenced on a lock timeout or on loss of lock while running.
module present_core_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  present_core_rst_seq_if.master  bus
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // The shared counter only ever needs to reach (largest window - 1).
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               relock_inc;
  logic [7:0]         relock_q;
  logic               pll_rst_q;
  logic               sys_rst_q;
  logic               ready_q;

  // Bring the asynchronous lock indication into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state and counter logic.
  // The counter clears on every state change.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    relock_inc = 1'b0;
    case (state_q)
      PLL_RESET: begin
        // Lock is deliberately ignored while the PLL is held in reset.
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout that lands on the same edge.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = PLL_RESET;
          relock_inc = 1'b1;
        end
      end
      STABLE: begin
        // Any dropout restarts the whole settling window.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d    = PLL_RESET;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RESET;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State, counter, recovery count and outputs.
  // Outputs are decoded from the next state so they change on the transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      relock_q  <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (relock_inc && (relock_q != 8'hFF)) begin
        relock_q <= relock_q + 8'd1;
      end
      pll_rst_q <= (state_d == PLL_RESET);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.ready        = ready_q;
  assign bus.relock_count = relock_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_present_core_rst_seq.sv
// Directed bench for present_core_rst_seq with short windows.
// Expected values are hand-derived edge counts from the sequencer's timing rules.
module tb_present_core_rst_seq;

  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 32;
  localparam int STABLE_CYCLES  = 8;
  localparam int SYNC_STAGES    = 2;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  present_core_rst_seq_if bus ();

  present_core_rst_seq #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int prst,
                            input int srst, input int rdy, input int rc);
    check({tag, ".state"},        32'(bus.state),        32'(st));
    check({tag, ".pll_rst"},      32'(bus.pll_rst),      32'(prst));
    check({tag, ".sys_rst"},      32'(bus.sys_rst),      32'(srst));
    check({tag, ".ready"},        32'(bus.ready),        32'(rdy));
    check({tag, ".relock_count"}, 32'(bus.relock_count), 32'(rc));
  endtask

  // drivers: inputs change and outputs are sampled 1 time unit after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst        = 1'b1;
    bus.locked = 1'b0;
    steps(2);
    check_outs("reset", 0, 1, 1, 0, 0);

    // Power-up: pll_rst high for 4 edges, lock raised 10 cycles after release
    rst = 1'b0;
    steps(3);
    check_outs("pwr_e3", 0, 1, 1, 0, 0);
    step();
    check_outs("pwr_e4", 1, 0, 1, 0, 0);
    steps(6);
    bus.locked = 1'b1;
    steps(2);
    check("pwr_lk2.state", 32'(bus.state), 32'd1);
    step();
    check("pwr_lk3.state", 32'(bus.state), 32'd2);
    steps(7);
    check_outs("pwr_lk10", 2, 0, 1, 0, 0);
    step();
    check_outs("pwr_lk11", 3, 0, 0, 1, 0);

    // Lock loss in RUN: one-cycle drop
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    step();
    check_outs("loss_e2", 3, 0, 0, 1, 0);
    step();
    check_outs("loss_e3", 0, 1, 1, 0, 1);
    steps(3);
    check("loss_e6.pll_rst", 32'(bus.pll_rst), 32'd1);
    step();
    check_outs("loss_e7", 1, 0, 1, 0, 1);
    step();
    check("loss_e8.state", 32'(bus.state), 32'd2);
    steps(7);
    check_outs("loss_e15", 2, 0, 1, 0, 1);
    step();
    check_outs("loss_e16", 3, 0, 0, 1, 1);

    // Async reset in RUN, between edges
    #2 rst = 1'b1;
    #1;
    check_outs("arst", 0, 1, 1, 0, 0);
    rst = 1'b0;

    // Glitch in STABLE after 5 counted stable cycles (locked still high)
    steps(4);
    check("gl_e4.state", 32'(bus.state), 32'd1);
    step();
    check("gl_e5.state", 32'(bus.state), 32'd2);
    steps(3);
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    step();
    check("gl_e10.state", 32'(bus.state), 32'd2);
    step();
    check_outs("gl_e11", 1, 0, 1, 0, 0);
    step();
    check("gl_e12.state", 32'(bus.state), 32'd2);
    steps(7);
    check_outs("gl_e19", 2, 0, 1, 0, 0);
    step();
    check_outs("gl_e20", 3, 0, 0, 1, 0);

    // Lock arriving on the timeout edge: WAIT_LOCK entered at loss edge 7,
    // timeout edge is 39, locked first sampled at 37
    bus.locked = 1'b0;
    steps(3);
    check_outs("lt_e3", 0, 1, 1, 0, 1);
    steps(4);
    check_outs("lt_e7", 1, 0, 1, 0, 1);
    steps(29);
    bus.locked = 1'b1;
    steps(2);
    check_outs("lt_e38", 1, 0, 1, 0, 1);
    step();
    check_outs("lt_e39", 2, 0, 1, 0, 1);
    step();
    check_outs("lt_e40", 2, 0, 1, 0, 1);

    // Timeout: locked held low, 36-cycle period, relock_count saturating
    #2 rst = 1'b1;
    bus.locked = 1'b0;
    #1 rst = 1'b0;
    steps(4);
    check_outs("to_e4", 1, 0, 1, 0, 0);
    steps(31);
    check_outs("to_e35", 1, 0, 1, 0, 0);
    step();
    check_outs("to_e36", 0, 1, 1, 0, 1);
    steps(3);
    check("to_e39.pll_rst", 32'(bus.pll_rst), 32'd1);
    step();
    check_outs("to_e40", 1, 0, 1, 0, 1);
    steps(31);
    check("to_e71.pll_rst", 32'(bus.pll_rst), 32'd0);
    step();
    check_outs("to_e72", 0, 1, 1, 0, 2);
    for (int n = 3; n <= 257; n++) begin
      steps(36);
      check("to_sat.relock_count", 32'(bus.relock_count), (n > 255) ? 32'd255 : 32'(n));
    end
    check_outs("to_end", 0, 1, 1, 0, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
